// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, addresses the combinational ROM
// and registers the fetched word into IF/ID, sequencing redirects/stalls/flushes.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC  = 32'h8000_0004,
  parameter logic [31:0] XADR_PC   = 32'h8000_0008,
  parameter int          ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        irq,
  input  logic        exception,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] epc,
  output logic        fetch_fault
);

  localparam logic [28:0] ROM_LIMIT = 29'(ROM_WORDS);

  typedef enum logic [2:0] {
    SEL_EXC, SEL_OOB, SEL_IRQ, SEL_BR, SEL_JR, SEL_JMP, SEL_STALL, SEL_SEQ
  } sel_e;

  typedef enum logic [1:0] {
    IFID_LOAD, IFID_HOLD, IFID_BUBBLE
  } ifid_e;

  logic [31:0] pc_r;
  logic [31:0] if_id_instr_r;
  logic [31:0] if_id_pc_plus4_r;
  logic        if_id_valid_r;
  logic [31:0] epc_r;
  logic        fetch_fault_r;

  logic [31:0] pc_plus4_s;
  logic        oob_s;
  logic        interrupt_ok_s;
  sel_e        sel_s;
  ifid_e       ifid_mode_s;
  logic [31:0] pc_next_s;
  logic [31:0] epc_next_s;
  logic        fault_next_s;
  logic [31:0] instr_next_s;
  logic [31:0] pp4_next_s;
  logic        valid_next_s;

  // Kernel bit is kept; only the low 31 bits increment (and wrap).
  assign pc_plus4_s     = {pc_r[31], pc_r[30:0] + 31'd4};
  assign oob_s          = (pc_r[30:2] >= ROM_LIMIT);
  assign interrupt_ok_s = irq & ~pc_r[31] & ~stall;

  // Fixed-priority choice of what drives the next PC.
  always_comb begin
    sel_s = SEL_SEQ;
    if (exception) begin
      sel_s = SEL_EXC;
    end else if (oob_s) begin
      sel_s = SEL_OOB;
    end else if (interrupt_ok_s) begin
      sel_s = SEL_IRQ;
    end else if (branch_taken) begin
      sel_s = SEL_BR;
    end else if (jr) begin
      sel_s = SEL_JR;
    end else if (jump) begin
      sel_s = SEL_JMP;
    end else if (stall) begin
      sel_s = SEL_STALL;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next PC, EPC, fault pulse and IF/ID action for the selected source.
  always_comb begin
    pc_next_s    = pc_plus4_s;
    epc_next_s   = epc_r;
    fault_next_s = 1'b0;
    ifid_mode_s  = IFID_BUBBLE;
    case (sel_s)
      SEL_EXC: begin
        pc_next_s  = XADR_PC;
        epc_next_s = if_id_pc_plus4_r;
      end
      SEL_OOB: begin
        pc_next_s    = XADR_PC;
        epc_next_s   = pc_plus4_s;
        fault_next_s = 1'b1;
      end
      SEL_IRQ: begin
        // Return to the fetch being squashed now.
        pc_next_s  = ILLOP_PC;
        epc_next_s = pc_r;
      end
      SEL_BR:  pc_next_s = branch_target;
      SEL_JR:  pc_next_s = jr_target;
      SEL_JMP: pc_next_s = jump_target;
      SEL_STALL: begin
        pc_next_s = pc_r;
        if (flush) begin
          ifid_mode_s = IFID_BUBBLE;
        end else begin
          ifid_mode_s = IFID_HOLD;
        end
      end
      SEL_SEQ: begin
        pc_next_s = pc_plus4_s;
        if (flush) begin
          ifid_mode_s = IFID_BUBBLE;
        end else begin
          ifid_mode_s = IFID_LOAD;
        end
      end
      default: begin
        pc_next_s   = XADR_PC;
        ifid_mode_s = IFID_BUBBLE;
      end
    endcase
  end

  // IF/ID register input mux.
  always_comb begin
    instr_next_s = 32'h0000_0000;
    pp4_next_s   = 32'h0000_0000;
    valid_next_s = 1'b0;
    case (ifid_mode_s)
      IFID_LOAD: begin
        instr_next_s = rom_data;
        pp4_next_s   = pc_plus4_s;
        valid_next_s = 1'b1;
      end
      IFID_HOLD: begin
        instr_next_s = if_id_instr_r;
        pp4_next_s   = if_id_pc_plus4_r;
        valid_next_s = if_id_valid_r;
      end
      IFID_BUBBLE: begin
        instr_next_s = 32'h0000_0000;
        pp4_next_s   = 32'h0000_0000;
        valid_next_s = 1'b0;
      end
      default: begin
        instr_next_s = 32'h0000_0000;
        pp4_next_s   = 32'h0000_0000;
        valid_next_s = 1'b0;
      end
    endcase
  end

  // PC, IF/ID, EPC and fault state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r             <= RESET_PC;
      if_id_instr_r    <= 32'h0000_0000;
      if_id_pc_plus4_r <= 32'h0000_0000;
      if_id_valid_r    <= 1'b0;
      epc_r            <= 32'h0000_0000;
      fetch_fault_r    <= 1'b0;
    end else begin
      pc_r             <= pc_next_s;
      if_id_instr_r    <= instr_next_s;
      if_id_pc_plus4_r <= pp4_next_s;
      if_id_valid_r    <= valid_next_s;
      epc_r            <= epc_next_s;
      fetch_fault_r    <= fault_next_s;
    end
  end

  assign rom_addr       = pc_r;
  assign if_id_instr    = if_id_instr_r;
  assign if_id_pc_plus4 = if_id_pc_plus4_r;
  assign if_id_valid    = if_id_valid_r;
  assign epc            = epc_r;
  assign fetch_fault    = fetch_fault_r;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch rules.
module tb_ifetch_ctrl;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC  = 32'h8000_0004;
  localparam logic [31:0] XADR_PC   = 32'h8000_0008;
  localparam int          ROM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr, rom_data;
  logic        stall, flush, branch_taken, jr, jump, irq, exception;
  logic [31:0] branch_target, jr_target, jump_target;
  logic [31:0] if_id_instr, if_id_pc_plus4, epc;
  logic        if_id_valid, fetch_fault;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_instr, m_pp4, m_epc;
  logic        m_valid, m_fault;

  ifetch_ctrl dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .jr(jr), .jr_target(jr_target),
    .jump(jump), .jump_target(jump_target), .irq(irq), .exception(exception),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .epc(epc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_C3C3;
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rom_addr", rom_addr, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc_plus4", if_id_pc_plus4, m_pp4);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check("epc", epc, m_epc);
    check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 32'd0; m_pp4 = 32'd0;
    m_valid = 1'b0; m_epc = 32'd0; m_fault = 1'b0;
  endtask

  // One clock of the fetch rules, evaluated on the model's own state.
  task automatic model_step();
    logic [31:0] seq;
    logic [31:0] word;
    logic        redirect;
    if (!reset) begin
      model_reset();
      return;
    end
    seq      = {m_pc[31], m_pc[30:0] + 31'd4};
    word     = rom_word(m_pc);
    redirect = 1'b1;
    m_fault  = 1'b0;
    if (exception) begin
      m_epc = m_pp4; m_pc = XADR_PC;
    end else if (int'(m_pc[30:2]) >= ROM_WORDS) begin
      m_epc = seq; m_pc = XADR_PC; m_fault = 1'b1;
    end else if (irq && !m_pc[31] && !stall) begin
      m_epc = m_pc; m_pc = ILLOP_PC;
    end else if (branch_taken) begin
      m_pc = branch_target;
    end else if (jr) begin
      m_pc = jr_target;
    end else if (jump) begin
      m_pc = jump_target;
    end else begin
      redirect = 1'b0;
    end
    if (redirect || flush) begin
      m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = word; m_pp4 = seq; m_valid = 1'b1;
    end
    if (!redirect && !stall) m_pc = seq;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jr = 1'b0; jump = 1'b0;
    irq = 1'b0; exception = 1'b0;
  endtask

  function automatic logic [31:0] rand_target();
    logic [8:0] idx;
    logic       k;
    idx = 9'($urandom_range(0, 300));
    k   = ($urandom_range(0, 3) == 0);
    return {k, 20'd0, idx, 2'b00};
  endfunction

  initial begin
    reset = 1'b0;
    idle();
    branch_target = 32'd0; jr_target = 32'd0; jump_target = 32'd0;
    model_reset();
    #12;
    check_all();
    check("reset_pc", rom_addr, 32'h8000_0000);

    // Reset release, sequential fetch.
    reset = 1'b1;
    cycle();
    check("first_pc", rom_addr, 32'h8000_0004);
    check("first_pp4", if_id_pc_plus4, 32'h8000_0004);
    check("first_valid", {31'd0, if_id_valid}, 32'd1);
    cycle();
    check("second_pc", rom_addr, 32'h8000_0008);

    // Stall at pc 0x10 for three cycles.
    jump = 1'b1; jump_target = 32'h0000_000C;
    cycle();
    idle();
    cycle();
    check("pre_stall_pc", rom_addr, 32'h0000_0010);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_pc", rom_addr, 32'h0000_0010);
      check("stall_pp4", if_id_pc_plus4, 32'h0000_0010);
    end
    stall = 1'b0;
    cycle();
    check("post_stall_pc", rom_addr, 32'h0000_0014);

    // Branch beats a simultaneous jump.
    jump = 1'b1; jump_target = 32'h0000_0040;
    branch_taken = 1'b1; branch_target = 32'h0000_0020;
    cycle();
    check("br_over_jump", rom_addr, 32'h0000_0020);
    check("br_bubble", {31'd0, if_id_valid}, 32'd0);
    idle();

    // Interrupt at 0x100, no re-entry in kernel mode, retake after return.
    jump = 1'b1; jump_target = 32'h0000_0100;
    cycle();
    idle();
    irq = 1'b1;
    cycle();
    check("irq_pc", rom_addr, ILLOP_PC);
    check("irq_epc", epc, 32'h0000_0100);
    cycle();
    cycle();
    check("irq_no_reentry", rom_addr, 32'h8000_000C);
    jr = 1'b1; jr_target = 32'h0000_0100;
    cycle();
    check("jr_resume", rom_addr, 32'h0000_0100);
    jr = 1'b0;
    cycle();
    check("irq_retake", rom_addr, ILLOP_PC);
    idle();

    // Fetch beyond the ROM.
    jump = 1'b1; jump_target = 32'h0000_0400;
    cycle();
    idle();
    check("oob_pc", rom_addr, 32'h0000_0400);
    cycle();
    check("fault_pulse", {31'd0, fetch_fault}, 32'd1);
    check("fault_pc", rom_addr, XADR_PC);
    check("fault_epc", epc, 32'h0000_0404);
    cycle();
    check("fault_clear", {31'd0, fetch_fault}, 32'd0);

    // Exception beats simultaneous irq and stall.
    jump = 1'b1; jump_target = 32'h0000_0014;
    cycle();
    idle();
    cycle();
    check("exc_setup_pp4", if_id_pc_plus4, 32'h0000_0018);
    exception = 1'b1; irq = 1'b1; stall = 1'b1;
    cycle();
    check("exc_pc", rom_addr, XADR_PC);
    check("exc_epc", epc, 32'h0000_0018);
    check("exc_valid", {31'd0, if_id_valid}, 32'd0);
    idle();

    // Asynchronous reset in the middle of a cycle.
    cycle();
    cycle();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    reset = 1'b1;
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      stall         = ($urandom_range(0, 99) < 20);
      flush         = ($urandom_range(0, 99) < 15);
      branch_taken  = ($urandom_range(0, 99) < 8);
      jr            = ($urandom_range(0, 99) < 8);
      jump          = ($urandom_range(0, 99) < 8);
      irq           = ($urandom_range(0, 99) < 20);
      exception     = ($urandom_range(0, 99) < 4);
      branch_target = rand_target();
      jr_target     = rand_target();
      jump_target   = rand_target();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller in front of the combinational instruction ROM.
- Owns the PC, drives the ROM address and registers the fetched word into the IF/ID pipeline register.
- Sequences PC redirects (exception, interrupt, branch, jump-register, jump), pipeline stalls and flushes, and out-of-range fetch faults, so the ROM sees one well-defined address per cycle.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset (kernel mode, bit 31 set).
- ILLOP_PC, 32'h8000_0004, interrupt vector.
- XADR_PC, 32'h8000_0008, exception / fetch-fault vector.
- ROM_WORDS, 256, number of valid ROM words; word index is pc[30:2].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rom_addr  out  32  byte address to ROM, equal to pc.
- rom_data  in  32  ROM read data, combinational from rom_addr.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  squash current IF/ID contents.
- branch_taken  in  1  EX-stage taken branch.
- branch_target  in  32  branch target.
- jr  in  1  ID-stage jr/jalr.
- jr_target  in  32  register target; may clear bit 31.
- jump  in  1  ID-stage j/jal.
- jump_target  in  32  jump target.
- irq  in  1  level interrupt request from peripherals.
- exception  in  1  ID-stage undefined-instruction exception.
- if_id_instr  out  32  registered instruction.
- if_id_pc_plus4  out  32  registered pc+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- epc  out  32  registered return address for interrupt/exception.
- fetch_fault  out  1  one-cycle pulse: fetch beyond ROM_WORDS.

Behaviour:
- Reset (reset low, async):
  - pc=RESET_PC, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, epc=0, fetch_fault=0.
  - Reset mid-operation discards everything in flight.
- rom_addr is pc combinationally. IF/ID is loaded from rom_data on the next rising edge: zero-cycle ROM latency, one-cycle fetch-to-ID latency.
- pc_plus4 = {pc[31], pc[30:0]+4}. The kernel bit is preserved; bits 30:0 wrap to 0 after 31'h7FFF_FFFC.
- interrupt_ok = irq & ~pc[31] & ~stall. Interrupts are never taken in kernel mode or while stalled; the request stays pending until irq is dropped.
- oob = pc[30:2] >= ROM_WORDS.
- Next-PC priority, highest first, evaluated each cycle:
  1. exception: pc<=XADR_PC, epc<=if_id_pc_plus4, IF/ID<=bubble.
  2. oob: pc<=XADR_PC, epc<=pc_plus4, fetch_fault<=1, IF/ID<=bubble.
  3. interrupt_ok: pc<=ILLOP_PC, epc<=pc (the squashed fetch resumes), IF/ID<=bubble.
  4. branch_taken: pc<=branch_target, IF/ID<=bubble. The hazard unit asserts flush for the ID instruction in the same cycle.
  5. jr: pc<=jr_target, IF/ID<=bubble.
  6. jump: pc<=jump_target, IF/ID<=bubble.
  7. stall: pc and IF/ID hold.
  8. Otherwise: pc<=pc_plus4, IF/ID<={rom_data, pc_plus4, valid=1}.
- Redirects 1-6 override stall. A redirect during stall still moves pc and inserts a bubble.
- flush with no redirect and no stall: IF/ID<=bubble and pc advances.
- flush with stall: IF/ID<=bubble and pc holds.
- Bubble = instr 32'h0000_0000 (nop), pc_plus4 0, valid 0.
- fetch_fault deasserts the cycle after it is raised. epc changes only on priorities 1-3.
- Simultaneous branch_taken and jr/jump: branch wins, because the EX instruction is older.

Test Plan:
- Reset release, stall=0, no redirects → rom_addr 0x80000000, 0x80000004, 0x80000008 on successive cycles; if_id_valid rises at first edge with if_id_pc_plus4=0x80000004.
- pc=0x00000010, stall high 3 cycles → rom_addr held at 0x10, IF/ID unchanged, valid unchanged; advances to 0x14 the cycle after stall drops.
- Same cycle: jump (target 0x00000040) and branch_taken (target 0x00000020) → next rom_addr 0x20, if_id_valid=0.
- irq=1 at pc=0x00000100 → pc=0x80000004, epc=0x00000100. With irq still high, no re-entry while pc[31]=1. jr_target 0x00000100 then resumes fetch at 0x100 and retakes the interrupt if irq is still high.
- jump_target 0x00000400 (word 256, ROM_WORDS=256) → fetch_fault pulses exactly one cycle, pc=0x80000008, epc=0x00000404.
- exception with if_id_pc_plus4=0x00000018 plus simultaneous irq and stall → pc=0x80000008, epc=0x00000018, if_id_valid=0. Then pulse reset low mid-fetch → all outputs return to reset values immediately.
